load_store_unit: RTL

//  Memory-stage load/store engine. It drives the data-memory request bus for load and store instructions.
//  For loads it produces the aligned, extended load word DDT that register writeback selects.
//  It stalls the pipeline while a bus transaction is outstanding.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_lane_align.sv | 51 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared opcode/func constants and legality helpers for the load/store unit.
package load_store_unit_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    function automatic logic func_legal(
        input logic       store,
        input logic [2:0] func
    );
        if (store)
            return func inside {F_SB, F_SH, F_SW};
        return func inside {F_LB, F_LH, F_LW, F_LBU, F_LHU};
    endfunction

    // func[1:0] encodes access size for both loads and stores
    function automatic logic addr_aligned(
        input logic [2:0] func,
        input logic [1:0] off
    );
        case (func[1:0])
            2'b01:   return !off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  func,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        if (is_store) begin
            case (func[1:0])
                2'b00: begin
                    be    = 4'b0001 << offset;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << {offset[1], 1'b0};
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
    end

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (func)
            F_LB:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F_LH:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F_LBU:   load_data = {24'd0, shifted[7:0]};
            F_LHU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: bus request FSM, timeout abort,
// and the held load-data register consumed by writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] DDT,
    output logic        misalign,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [7:0]  cnt;
    logic        st_q;
    logic [2:0]  func_q;
    logic [31:0] addr_q;
    logic [31:0] rs2_q;
    logic [31:0] ddt_q;
    logic        fault_q;
    logic        misalign_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        legal;
    logic        idle;
    logic        in_req;
    logic        in_wait;
    logic        issue;
    logic        bad;
    logic        cnt_last;
    logic        capture;
    logic        abort;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;
    logic        unused_inst;

    assign is_load  = inst[6:0] == OP_LOAD;
    assign is_store = inst[6:0] == OP_STORE;
    assign is_mem   = is_load || is_store;
    assign legal    = func_legal(is_store, inst[14:12])
                   && addr_aligned(inst[14:12], addr[1:0]);

    assign idle     = state == S_IDLE;
    assign in_req   = state == S_REQ;
    assign in_wait  = state == S_WAIT;
    assign issue    = idle && start && is_mem && legal;
    assign bad      = idle && start && is_mem && !legal;
    assign cnt_last = (cnt + 8'd1) == TMO;

    assign unused_inst = ^{inst[31:15], inst[11:7]};

    lsu_lane_align u_align (
        .is_store   (st_q),
        .func       (func_q),
        .offset     (addr_q[1:0]),
        .store_data (rs2_q),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (ld_data)
    );

    // Completion is checked before the timeout so late data still wins
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                if (mem_gnt && (st_q || mem_rvalid)) begin
                    state_nx = S_DONE;
                    capture  = !st_q;
                end else if (cnt_last) begin
                    state_nx = S_DONE;
                    abort    = 1'b1;
                end else if (mem_gnt) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nx = S_DONE;
                    capture  = 1'b1;
                end else if (cnt_last) begin
                    state_nx = S_DONE;
                    abort    = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            st_q       <= 1'b0;
            func_q     <= '0;
            addr_q     <= '0;
            rs2_q      <= '0;
            ddt_q      <= '0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nx;
            fault_q    <= abort;
            misalign_q <= bad;
            if (issue) begin
                st_q   <= is_store;
                func_q <= inst[14:12];
                addr_q <= addr;
                rs2_q  <= rs2_data;
                cnt    <= '0;
            end else if (in_req || in_wait) begin
                cnt <= cnt + 8'd1;
            end
            if (capture)
                ddt_q <= ld_data;
        end
    end

    assign busy      = issue || in_req || in_wait;
    assign done      = state == S_DONE;
    assign fault     = fault_q;
    assign misalign  = misalign_q;
    assign DDT       = ddt_q;
    assign mem_req   = in_req;
    assign mem_we    = in_req && st_q;
    assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be    = in_req ? be : '0;
    assign mem_wdata = in_req ? wdata : '0;

endmodule
